// File: rtl/uart_irq_pkg.sv
// Shared definitions for the UART interrupt controller: status bit positions,
// FIFO trigger-level codes and the trigger-level lookup.
package uart_irq_pkg;

    localparam int IRQ_W  = 11;
    localparam int IRQ_RI  = 0;
    localparam int IRQ_CTS = 1;
    localparam int IRQ_DCD = 2;
    localparam int IRQ_DSR = 3;
    localparam int IRQ_RX  = 4;
    localparam int IRQ_TX  = 5;
    localparam int IRQ_RT  = 6;
    localparam int IRQ_FE  = 7;
    localparam int IRQ_PE  = 8;
    localparam int IRQ_BE  = 9;
    localparam int IRQ_OE  = 10;

    typedef enum logic [2:0] {
        IFLS_1_8 = 3'b000,
        IFLS_1_4 = 3'b001,
        IFLS_1_2 = 3'b010,
        IFLS_3_4 = 3'b011,
        IFLS_7_8 = 3'b100
    } ifls_e;

    // Codes 101..111 are treated as 7/8 full.
    function automatic int trig_level(input logic [2:0] code, input int depth);
        case (code)
            IFLS_1_8: trig_level = depth / 8;
            IFLS_1_4: trig_level = depth / 4;
            IFLS_1_2: trig_level = depth / 2;
            IFLS_3_4: trig_level = (depth / 4) * 3;
            default:  trig_level = (depth / 8) * 7;
        endcase
    endfunction

endpackage

// File: rtl/uart_irq_timeout.sv
// RX idle timeout: counts bclk ticks while the RX FIFO holds data untouched and
// pulses fire_o once, on the tick that completes TIMEOUT_TICKS idle ticks.
module uart_irq_timeout #(
    parameter int  TIMEOUT_TICKS = 512,
    localparam int CNT_W         = $clog2(TIMEOUT_TICKS)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic clr_i,
    output logic fire_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // Counter parks at CNT_MAX; sat_q keeps fire_o to a single pulse per idle period.
    always_comb begin
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        fire_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (tick_i) begin
            if (cnt_q == CNT_MAX) begin
                sat_d  = 1'b1;
                fire_o = ~sat_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: raw status, mask, write-1-to-clear and FIFO trigger levels.
// Define UART_IRQ_SPLIT_EN to add per-group interrupt outputs alongside irq_o.
module uart_irq_ctrl
    import uart_irq_pkg::*;
#(
    parameter int  FIFO_DEPTH    = 32,
    parameter int  TIMEOUT_TICKS = 512,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bclk_tick_i,
    input  logic [LVL_W-1:0] rx_level_i,
    input  logic [LVL_W-1:0] tx_level_i,
    input  logic             rx_push_i,
    input  logic             rx_pop_i,
    input  logic             rx_fe_i,
    input  logic             rx_pe_i,
    input  logic             rx_be_i,
    input  logic             rx_oe_i,
    input  logic [3:0]       modem_i,
    input  logic             imsc_we_i,
    input  logic [10:0]      imsc_wdata_i,
    input  logic             icr_we_i,
    input  logic [10:0]      icr_wdata_i,
    input  logic             ifls_we_i,
    input  logic [5:0]       ifls_wdata_i,
    output logic [10:0]      imsc_o,
    output logic [5:0]       ifls_o,
    output logic [10:0]      ris_o,
    output logic [10:0]      mis_o,
`ifdef UART_IRQ_SPLIT_EN
    output logic             irq_rx_o,
    output logic             irq_tx_o,
    output logic             irq_err_o,
    output logic             irq_ms_o,
`endif
    output logic             irq_o
);

    logic [IRQ_W-1:0] ris_q, ris_d, imsc_q, imsc_d, clr, mis;
    logic [5:0]       ifls_q, ifls_d;
    logic [3:0]       prev_q, prev_d;
    logic             first_q, first_d;
    logic             irq_q, irq_d;
    logic [LVL_W-1:0] rx_trig, tx_trig;
    logic             rx_empty, rt_clr, rt_fire;

    assign rx_empty = (rx_level_i == '0);
    assign rt_clr   = rx_push_i | rx_pop_i | rx_empty;
    assign mis      = ris_q & imsc_q;

    uart_irq_timeout #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_i (bclk_tick_i),
        .clr_i  (rt_clr),
        .fire_o (rt_fire)
    );

    always_comb begin
        clr     = icr_we_i ? icr_wdata_i : '0;
        rx_trig = LVL_W'(trig_level(ifls_q[5:3], FIFO_DEPTH));
        tx_trig = LVL_W'(trig_level(ifls_q[2:0], FIFO_DEPTH));
        ris_d   = ris_q & ~clr;
        // Level-driven bits: while the condition holds it overrides any ICR clear.
        ris_d[IRQ_RX] = (rx_level_i >= rx_trig);
        ris_d[IRQ_TX] = (tx_level_i <= tx_trig);
        ris_d[IRQ_RT] = rt_fire | (ris_q[IRQ_RT] & ~clr[IRQ_RT] & ~rx_pop_i & ~rx_empty);
        ris_d[IRQ_FE] = ris_d[IRQ_FE] | rx_fe_i;
        ris_d[IRQ_PE] = ris_d[IRQ_PE] | rx_pe_i;
        ris_d[IRQ_BE] = ris_d[IRQ_BE] | rx_be_i;
        ris_d[IRQ_OE] = ris_d[IRQ_OE] | rx_oe_i;
        // First cycle out of reset only primes the previous-value registers.
        if (!first_q) ris_d[IRQ_DSR:IRQ_RI] = ris_d[IRQ_DSR:IRQ_RI] | (modem_i ^ prev_q);
        prev_d  = modem_i;
        first_d = 1'b0;
        imsc_d  = imsc_we_i ? imsc_wdata_i : imsc_q;
        ifls_d  = ifls_we_i ? ifls_wdata_i : ifls_q;
        irq_d   = |mis;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ris_q   <= '0;
            imsc_q  <= '0;
            ifls_q  <= 6'b010_010;
            prev_q  <= '0;
            first_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            ris_q   <= ris_d;
            imsc_q  <= imsc_d;
            ifls_q  <= ifls_d;
            prev_q  <= prev_d;
            first_q <= first_d;
            irq_q   <= irq_d;
        end
    end

    assign ris_o  = ris_q;
    assign imsc_o = imsc_q;
    assign ifls_o = ifls_q;
    assign mis_o  = mis;
    assign irq_o  = irq_q;

`ifdef UART_IRQ_SPLIT_EN
    logic irq_rx_q, irq_rx_d, irq_tx_q, irq_tx_d, irq_err_q, irq_err_d, irq_ms_q, irq_ms_d;

    always_comb begin
        irq_rx_d  = mis[IRQ_RX] | mis[IRQ_RT];
        irq_tx_d  = mis[IRQ_TX];
        irq_err_d = |mis[IRQ_OE:IRQ_FE];
        irq_ms_d  = |mis[IRQ_DSR:IRQ_RI];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_rx_q  <= 1'b0;
            irq_tx_q  <= 1'b0;
            irq_err_q <= 1'b0;
            irq_ms_q  <= 1'b0;
        end else begin
            irq_rx_q  <= irq_rx_d;
            irq_tx_q  <= irq_tx_d;
            irq_err_q <= irq_err_d;
            irq_ms_q  <= irq_ms_d;
        end
    end

    assign irq_rx_o  = irq_rx_q;
    assign irq_tx_o  = irq_tx_q;
    assign irq_err_o = irq_err_q;
    assign irq_ms_o  = irq_ms_q;
`endif

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Self-checking bench for uart_irq_ctrl: directed scenarios plus a randomized run,
// compared every cycle against a behavioural model of the interrupt rules.
module tb_uart_irq_ctrl;

    localparam int D  = 32;
    localparam int TT = 512;
    localparam int LW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          bclk_tick_i = 1'b0;
    logic [LW-1:0] rx_level_i = '0, tx_level_i = '0;
    logic          rx_push_i = 1'b0, rx_pop_i = 1'b0;
    logic          rx_fe_i = 1'b0, rx_pe_i = 1'b0, rx_be_i = 1'b0, rx_oe_i = 1'b0;
    logic [3:0]    modem_i = '0;
    logic          imsc_we_i = 1'b0, icr_we_i = 1'b0, ifls_we_i = 1'b0;
    logic [10:0]   imsc_wdata_i = '0, icr_wdata_i = '0;
    logic [5:0]    ifls_wdata_i = '0;
    logic [10:0]   imsc_o, ris_o, mis_o;
    logic [5:0]    ifls_o;
    logic          irq_o;
`ifdef UART_IRQ_SPLIT_EN
    logic          irq_rx_o, irq_tx_o, irq_err_o, irq_ms_o;
`endif

    uart_irq_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_TICKS(TT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bclk_tick_i(bclk_tick_i),
        .rx_level_i(rx_level_i), .tx_level_i(tx_level_i),
        .rx_push_i(rx_push_i), .rx_pop_i(rx_pop_i),
        .rx_fe_i(rx_fe_i), .rx_pe_i(rx_pe_i), .rx_be_i(rx_be_i), .rx_oe_i(rx_oe_i),
        .modem_i(modem_i),
        .imsc_we_i(imsc_we_i), .imsc_wdata_i(imsc_wdata_i),
        .icr_we_i(icr_we_i), .icr_wdata_i(icr_wdata_i),
        .ifls_we_i(ifls_we_i), .ifls_wdata_i(ifls_wdata_i),
        .imsc_o(imsc_o), .ifls_o(ifls_o), .ris_o(ris_o), .mis_o(mis_o),
`ifdef UART_IRQ_SPLIT_EN
        .irq_rx_o(irq_rx_o), .irq_tx_o(irq_tx_o), .irq_err_o(irq_err_o), .irq_ms_o(irq_ms_o),
`endif
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [10:0] m_ris, m_imsc;
    logic [5:0]  m_ifls;
    logic        m_irq;
    logic [3:0]  m_prev;
    bit          m_first;
    int          m_idle;

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
    endtask

    function automatic int trig(input logic [2:0] k);
        case (k)
            3'd0:    return D / 8;
            3'd1:    return D / 4;
            3'd2:    return D / 2;
            3'd3:    return 3 * D / 4;
            default: return 7 * D / 8;
        endcase
    endfunction

    task automatic model_reset();
        m_ris = '0; m_imsc = '0; m_ifls = 6'b010_010; m_irq = 1'b0;
        m_prev = '0; m_first = 1'b1; m_idle = 0;
    endtask

    // One clock: predict from the inputs presented, clock the DUT, compare, drop pulses.
    task automatic cycle();
        logic [10:0] clr, n;
        logic        n_irq;
        int          n_idle;
        bit          idle_clr;
        clr = icr_we_i ? icr_wdata_i : 11'h0;
        n = m_ris & ~clr;
        n[4] = (int'(rx_level_i) >= trig(m_ifls[5:3]));
        n[5] = (int'(tx_level_i) <= trig(m_ifls[2:0]));
        idle_clr = rx_push_i || rx_pop_i || (rx_level_i == 0);
        n_idle = idle_clr ? 0 : m_idle + int'(bclk_tick_i);
        if (rx_pop_i || rx_level_i == 0) n[6] = 1'b0;
        if (!idle_clr && bclk_tick_i && n_idle == TT) n[6] = 1'b1;
        n[7] = n[7] | rx_fe_i;
        n[8] = n[8] | rx_pe_i;
        n[9] = n[9] | rx_be_i;
        n[10] = n[10] | rx_oe_i;
        if (!m_first)
            for (int i = 0; i < 4; i++)
                if (modem_i[i] != m_prev[i]) n[i] = 1'b1;
        n_irq = |(m_ris & m_imsc);
        @(posedge clk_i); #1;
        m_ris = n; m_idle = n_idle; m_irq = n_irq; m_prev = modem_i; m_first = 1'b0;
        if (imsc_we_i) m_imsc = imsc_wdata_i;
        if (ifls_we_i) m_ifls = ifls_wdata_i;
        chk("ris", ris_o, m_ris);
        chk("mis", mis_o, m_ris & m_imsc);
        chk("imsc", imsc_o, m_imsc);
        chk("ifls", {5'd0, ifls_o}, {5'd0, m_ifls});
        chk("irq", {10'd0, irq_o}, {10'd0, m_irq});
        bclk_tick_i = 0; rx_push_i = 0; rx_pop_i = 0;
        rx_fe_i = 0; rx_pe_i = 0; rx_be_i = 0; rx_oe_i = 0;
        imsc_we_i = 0; icr_we_i = 0; ifls_we_i = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ris"}, ris_o, 11'h000);
        chk({tag, "_mis"}, mis_o, 11'h000);
        chk({tag, "_imsc"}, imsc_o, 11'h000);
        chk({tag, "_ifls"}, {5'd0, ifls_o}, 11'h012);
        chk({tag, "_irq"}, {10'd0, irq_o}, 11'h000);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_state("rst");
        rst_i = 0;

        // RX trigger at default half-full
        rx_level_i = 6'd15; cycle();
        rx_level_i = 6'd16; rx_push_i = 1; cycle();
        chk("t1_rx_set", {10'd0, ris_o[4]}, 11'd1);
        rx_level_i = 6'd15; rx_pop_i = 1; cycle();
        chk("t1_rx_clr", {10'd0, ris_o[4]}, 11'd0);

        // Mask gating and two-cycle irq latency
        imsc_we_i = 1; imsc_wdata_i = 11'h010; rx_level_i = 6'd16; rx_push_i = 1; cycle();
        chk("t2_irq_lat1", {10'd0, irq_o}, 11'd0);
        cycle();
        chk("t2_irq_on", {10'd0, irq_o}, 11'd1);
        imsc_we_i = 1; imsc_wdata_i = 11'h000; cycle(); cycle();
        chk("t2_irq_off", {10'd0, irq_o}, 11'd0);
        chk("t2_ris_keep", {10'd0, ris_o[4]}, 11'd1);

        // RX idle timeout
        rx_level_i = 6'd3; rx_pop_i = 1; cycle();
        repeat (TT - 1) begin bclk_tick_i = 1; cycle(); end
        chk("t3_rt_early", {10'd0, ris_o[6]}, 11'd0);
        bclk_tick_i = 1; cycle();
        chk("t3_rt_set", {10'd0, ris_o[6]}, 11'd1);
        rx_pop_i = 1; cycle();
        chk("t3_rt_pop", {10'd0, ris_o[6]}, 11'd0);

        // Set beats clear on the same cycle
        rx_oe_i = 1; icr_we_i = 1; icr_wdata_i = 11'h400; cycle();
        chk("t4_oe_set", {10'd0, ris_o[10]}, 11'd1);
        icr_we_i = 1; icr_wdata_i = 11'h400; cycle();
        chk("t4_oe_clr", {10'd0, ris_o[10]}, 11'd0);

        // CTS edge, then a line already high across reset release
        modem_i = 4'b0010; cycle();
        chk("t5_cts_edge", {10'd0, ris_o[1]}, 11'd1);
        rst_i = 1; #1; model_reset();
        @(posedge clk_i); #1; rst_i = 0;
        repeat (3) cycle();
        chk("t5_cts_quiet", {10'd0, ris_o[1]}, 11'd0);

        // TX trigger at 7/8 and async reset mid-run
        ifls_we_i = 1; ifls_wdata_i = 6'b010_100; tx_level_i = 6'd30; cycle(); cycle();
        chk("t6_tx_above", {10'd0, ris_o[5]}, 11'd0);
        tx_level_i = 6'd28; cycle();
        chk("t6_tx_at", {10'd0, ris_o[5]}, 11'd1);
        imsc_we_i = 1; imsc_wdata_i = 11'h7ff; rx_fe_i = 1; cycle(); cycle();
        chk("t6_irq_pre", {10'd0, irq_o}, 11'd1);
        #2 rst_i = 1; #1;
        check_reset_state("t6_rst");
        model_reset();
        @(posedge clk_i); #1; rst_i = 0;

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) rx_level_i = LW'($urandom_range(0, D));
            if ($urandom_range(0, 7) == 0) tx_level_i = LW'($urandom_range(0, D));
            bclk_tick_i = ($urandom_range(0, 1) == 1);
            rx_push_i   = ($urandom_range(0, 15) == 0);
            rx_pop_i    = ($urandom_range(0, 15) == 0);
            rx_fe_i     = ($urandom_range(0, 19) == 0);
            rx_pe_i     = ($urandom_range(0, 19) == 0);
            rx_be_i     = ($urandom_range(0, 19) == 0);
            rx_oe_i     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) modem_i = modem_i ^ 4'($urandom_range(1, 15));
            imsc_we_i    = ($urandom_range(0, 9) == 0);
            imsc_wdata_i = 11'($urandom);
            icr_we_i     = ($urandom_range(0, 5) == 0);
            icr_wdata_i  = 11'($urandom);
            ifls_we_i    = ($urandom_range(0, 11) == 0);
            ifls_wdata_i = 6'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
